// File: rtl/fp_adder_pipe_if.sv
// Operand/result stream bundle for fp_adder_pipe: operand pair in, packed result
// plus status flags out, each direction with its own valid/ready handshake.
interface fp_adder_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) ();
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         overflow;
    logic         underflow;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, overflow, underflow
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, overflow, underflow
    );
endinterface

// File: rtl/fp_adder_pipe.sv
// 3-stage pipelined FP add/subtract: S1 unpack/align, S2 add, S3 normalise/pack.
// Define FPADD_RNE_EN for round-to-nearest-even; the default build truncates.
module fp_adder_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic            clk,
    input  logic            rst,
    fp_adder_pipe_if.slave  io
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int MW  = MAN_W + 4;              // hidden + mantissa + G,R,S
    localparam int EW  = EXP_W + 2;
    localparam int LZW = $clog2(MW + 1) + 1;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] SH_SAT   = EXP_W'(MAN_W + 3);
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    // pipeline state
    logic [2:0]   vld_q, vld_d;
    logic         s1_sign_q, s1_sign_d;
    logic         s1_sub_q, s1_sub_d;
    logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
    logic [MW-1:0] s1_ml_q, s1_ml_d;
    logic [MW-1:0] s1_ms_q, s1_ms_d;
    logic         s1_spec_q, s1_spec_d;
    logic [W-1:0] s1_sval_q, s1_sval_d;
    logic         s2_sign_q, s2_sign_d;
    logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
    logic [MW:0]  s2_mag_q, s2_mag_d;
    logic         s2_spec_q, s2_spec_d;
    logic [W-1:0] s2_sval_q, s2_sval_d;
    logic [W-1:0] sum_q, sum_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;

    logic adv;
    assign adv          = !vld_q[2] || io.out_ready;
    assign io.in_ready  = adv;
    assign io.out_valid = vld_q[2];
    assign io.sum       = sum_q;
    assign io.overflow  = ovf_q;
    assign io.underflow = unf_q;

    assign vld_d = {vld_q[1:0], io.in_valid};

    // S1: unpack, classify, order by magnitude, align the smaller operand
    logic [EXP_W-1:0] ea, eb, el, es, d;
    logic             sa, sb, sl, ss, swap;
    logic             a_inf, b_inf, a_nan, b_nan;
    logic [EXP_W+MAN_W-1:0] ka, kb, kl, ks;
    logic [MW-1:0]    ext_l, ext_s, mag_s;
    logic [2*MW-1:0]  wide;

    always_comb begin
        ea    = io.a[W-2:MAN_W];
        eb    = io.b[W-2:MAN_W];
        sa    = io.a[W-1];
        sb    = io.b[W-1] ^ io.sub;
        a_inf = (ea == EXP_ONES);
        b_inf = (eb == EXP_ONES);
        a_nan = a_inf && (io.a[MAN_W-1:0] != '0);
        b_nan = b_inf && (io.b[MAN_W-1:0] != '0);
        // a zero exponent flushes the whole operand, so its mantissa never counts
        ka    = (ea == '0) ? '0 : io.a[W-2:0];
        kb    = (eb == '0) ? '0 : io.b[W-2:0];
        swap  = (kb > ka);
        kl    = swap ? kb : ka;
        ks    = swap ? ka : kb;
        sl    = swap ? sb : sa;
        ss    = swap ? sa : sb;
        el    = kl[EXP_W+MAN_W-1:MAN_W];
        es    = ks[EXP_W+MAN_W-1:MAN_W];
        ext_l = (el == '0) ? '0 : {1'b1, kl[MAN_W-1:0], 3'b000};
        ext_s = (es == '0) ? '0 : {1'b1, ks[MAN_W-1:0], 3'b000};
        d     = el - es;
        wide  = {ext_s, {MW{1'b0}}} >> d;
        if (d >= SH_SAT)
            mag_s = {{(MW-1){1'b0}}, |ext_s};
        else
            mag_s = {wide[2*MW-1:MW+1], wide[MW] | (|wide[MW-1:0])};

        s1_sign_d = sl;
        s1_sub_d  = sl ^ ss;
        s1_exp_d  = el;
        s1_ml_d   = ext_l;
        s1_ms_d   = mag_s;
        s1_spec_d = a_inf || b_inf;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            s1_sval_d = QNAN;
        else if (a_inf)
            s1_sval_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
        else
            s1_sval_d = {sb, EXP_ONES, {MAN_W{1'b0}}};
    end

    // S2: magnitude add or subtract; L >= S so the difference never goes negative
    always_comb begin
        s2_sign_d = s1_sign_q;
        s2_exp_d  = s1_exp_q;
        s2_spec_d = s1_spec_q;
        s2_sval_d = s1_sval_q;
        if (s1_sub_q)
            s2_mag_d = {1'b0, s1_ml_q} - {1'b0, s1_ms_q};
        else
            s2_mag_d = {1'b0, s1_ml_q} + {1'b0, s1_ms_q};
    end

    // S3: normalise, round, range check, pack
    logic [LZW-1:0]   lz;
    logic             found;
    logic [MW-1:0]    n;
    logic [EW-1:0]    e;
    logic [MAN_W-1:0] man;
`ifdef FPADD_RNE_EN
    logic             rup;
    logic [MAN_W+1:0] mr;
`endif

    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!found) begin
                if (s2_mag_q[i]) found = 1'b1;
                else             lz    = lz + LZW'(1);
            end
        end
        if (s2_mag_q[MW]) begin
            n = {s2_mag_q[MW:2], s2_mag_q[1] | s2_mag_q[0]};
            e = {2'b00, s2_exp_q} + EW'(1);
        end else begin
            n = s2_mag_q[MW-1:0] << lz;
            e = {2'b00, s2_exp_q} - EW'(lz);
        end
`ifdef FPADD_RNE_EN
        rup = n[2] & (n[1] | n[0] | n[3]);
        mr  = {1'b0, n[MW-1:3]} + (MAN_W+2)'(rup);
        if (mr[MAN_W+1]) begin
            e   = e + EW'(1);
            man = mr[MAN_W:1];
        end else begin
            man = mr[MAN_W-1:0];
        end
`else
        man = n[MW-2:3];
`endif

        sum_d = {s2_sign_q, e[EXP_W-1:0], man};
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (s2_spec_q) begin
            sum_d = s2_sval_q;
        end else if (s2_mag_q == '0) begin
            sum_d = '0;
        end else if (e[EW-1] || (e == '0)) begin
            sum_d = {s2_sign_q, {(W-1){1'b0}}};
            unf_d = 1'b1;
        end else if (e >= {2'b00, EXP_ONES}) begin
            sum_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
            ovf_d = 1'b1;
        end
    end

    // one enable stalls every stage together, so bubbles are never squeezed out
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            sum_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (adv) begin
            vld_q     <= vld_d;
            s1_sign_q <= s1_sign_d;
            s1_sub_q  <= s1_sub_d;
            s1_exp_q  <= s1_exp_d;
            s1_ml_q   <= s1_ml_d;
            s1_ms_q   <= s1_ms_d;
            s1_spec_q <= s1_spec_d;
            s1_sval_q <= s1_sval_d;
            s2_sign_q <= s2_sign_d;
            s2_exp_q  <= s2_exp_d;
            s2_mag_q  <= s2_mag_d;
            s2_spec_q <= s2_spec_d;
            s2_sval_q <= s2_sval_d;
            sum_q     <= sum_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end
endmodule

// File: tb/tb_fp_adder_pipe.sv
// Scoreboard bench for fp_adder_pipe (single precision): directed vectors,
// back-to-back issue, output stall and mid-flight reset.
module tb_fp_adder_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_adder_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();
    fp_adder_pipe #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst(rst), .io(bus.slave));

    typedef struct {
        logic [31:0] sum;
        logic        ovf;
        logic        unf;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int errors = 0;
    int checks = 0;
    int cyc    = 0;

`ifdef FPADD_RNE_EN
    localparam logic [31:0] R_TIE  = 32'h3F800000;
    localparam logic [31:0] R_UP   = 32'h3F800001;
    localparam logic [31:0] R_MAX  = 32'h7F800000;
    localparam logic        O_MAX  = 1'b1;
`else
    localparam logic [31:0] R_TIE  = 32'h3F800000;
    localparam logic [31:0] R_UP   = 32'h3F800000;
    localparam logic [31:0] R_MAX  = 32'h7F7FFFFF;
    localparam logic        O_MAX  = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h need %h", nm, act, req);
        end
    endtask

    // monitor: pop and compare every delivered result
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected: got sum %h with empty scoreboard", bus.sum);
            end else begin
                e = q.pop_front();
                chk("sum", bus.sum, e.sum);
                chk("overflow", 32'(bus.overflow), 32'(e.ovf));
                chk("underflow", 32'(bus.underflow), 32'(e.unf));
                if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd3);
            end
        end
    end

    task automatic send(logic [31:0] a_i, logic [31:0] b_i, logic s_i,
                        logic [31:0] r, logic o, logic u, bit push, bit lat);
        int n = 0;
        exp_t x;
        @(negedge clk);
        bus.a = a_i; bus.b = b_i; bus.sub = s_i; bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept: in_ready stuck at 0 need 1");
        end else if (push) begin
            x.sum = r; x.ovf = o; x.unf = u; x.acc = cyc; x.lat = lat;
            q.push_back(x);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results outstanding need 0", q.size());
            q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst sum", bus.sum, 32'h0);
        chk("rst overflow", 32'(bus.overflow), 32'd0);
        chk("rst underflow", 32'(bus.underflow), 32'd0);
        rst = 1'b0;

        // four back-to-back, exact 3-cycle latency each
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1, 1);
        send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0, 1, 1);
        send(32'h3FC00000, 32'hBFC00000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1, 1);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1, 1);
        drain();

        send(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1, 1);
        send(32'h4B800000, 32'h33800000, 1'b0, 32'h4B800000, 1'b0, 1'b0, 1, 1);
        send(32'h00000000, 32'h40490FDB, 1'b0, 32'h40490FDB, 1'b0, 1'b0, 1, 1);
        send(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0, 1, 1);
        send(32'hFF800001, 32'h00000000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1, 1);
        send(32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 1'b0, 1'b1, 1, 1);
        send(32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 1'b0, 1'b0, 1, 1);
        send(32'hC0000000, 32'h40400000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1, 1);
        send(32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1, 32'hFF800000, 1'b1, 1'b0, 1, 1);
        send(32'h3F800000, 32'h33800000, 1'b0, R_TIE, 1'b0, 1'b0, 1, 1);
        send(32'h3F800000, 32'h33800001, 1'b0, R_UP, 1'b0, 1'b0, 1, 1);
        send(32'h7F7FFFFF, 32'h73000000, 1'b0, R_MAX, O_MAX, 1'b0, 1, 1);
        drain();

        // output stall: results must hold and none may be lost or repeated
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1, 0);
        send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0, 1, 0);
        send(32'h00000000, 32'h40490FDB, 1'b0, 32'h40490FDB, 1'b0, 1'b0, 1, 0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        begin
            int n = 0;
            while (!bus.out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (5) begin
            @(negedge clk);
            chk("stall in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall out_valid", 32'(bus.out_valid), 32'd1);
            chk("stall sum", bus.sum, 32'h40000000);
        end
        bus.out_ready = 1'b1;
        drain();

        // reset with two operations in flight
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0);
        send(32'h40400000, 32'h3F800000, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post-rst out_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        send(32'hC0000000, 32'h40400000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp_adder_pipe.md
Name: fp_adder_pipe

Overview:
Parametrised, 3-stage pipelined floating-point adder/subtractor. It is the successor to the combinational single-precision adder.
- Adds: operand-sign handling (true subtraction), leading-zero normalisation, special-value handling, status flags and a valid/ready stream handshake.
- Sits between the operand-fetch stage and the result writeback stage of the FP datapath.

Parameters:
- EXP_W, 8, exponent field width in bits (bias = 2^(EXP_W-1)-1).
- MAN_W, 23, stored mantissa field width in bits (hidden bit implicit).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept the operand pair this cycle
- a  input  1+EXP_W+MAN_W  operand A {sign, exp, man}
- b  input  1+EXP_W+MAN_W  operand B
- sub  input  1  1: compute A-B (sign of B inverted at entry); 0: A+B
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- sum  output  1+EXP_W+MAN_W  result
- overflow  output  1  result saturated to infinity, qualified by out_valid
- underflow  output  1  nonzero exact result flushed to zero, qualified by out_valid

Behaviour:
- Only clk and rst are used; rst is synchronous and active-high.
- Reset: every valid bit cleared; out_valid=0, sum=0, overflow=0, underflow=0, in_ready=1 in the cycle after rst is sampled high. Any in-flight operations are discarded, with no partial output.
- Pipeline advance enable: adv = !out_valid || out_ready.
  - in_ready = adv.
  - A transfer occurs when in_valid && in_ready.
  - When adv=0, all stages hold; sum and flags stay stable while out_valid=1.
- Latency: 3 cycles from accept to out_valid with no stall. Throughput is 1 result/cycle. Bubbles propagate and are not compressed.
- S1 (unpack/align):
  - An exponent of 0 is treated as zero; denormals are flushed to zero.
  - Prepend the hidden bit.
  - Effective sign of B is b.sign XOR sub.
  - Swap so the larger magnitude (exp, then mantissa) is operand L.
  - Right-shift the smaller operand by the exponent difference. Keep guard, round and sticky bits (sticky = OR of bits shifted out).
  - A shift ≥ MAN_W+3 makes the small operand zero with sticky = (small != 0).
- S2 (add):
  - If signs are equal, add the magnitudes; otherwise subtract L-S.
  - Result width MAN_W+2 plus GRS bits. Result sign = sign of L.
- S3 (normalise/pack):
  - On carry-out, shift right 1 and increment the exponent.
  - Otherwise left-shift by the leading-zero count and decrement the exponent by that count.
  - Rounding: truncate (round toward zero) by default.
  - Exponent ≥ 2^EXP_W-1 → sum = {sign, all-ones, 0}, overflow=1.
  - Exponent ≤ 0 → sum = {sign, 0, 0}, underflow=1.
- Exact cancellation (zero magnitude): sum = +0, both flags 0.
- Specials, detected in S1 and carried down the pipe:
  - Any operand with exp all-ones is infinity/NaN.
  - inf + finite = that inf.
  - inf + inf with the same effective sign = inf.
  - Opposite-sign infinities or any NaN input → canonical quiet NaN {0, all-ones, 1 followed by zeros}.
  - overflow=0 for specials.
- Zero operands: 0+X = X, bit exact, for a normal X.

Optional Feature:
- Macro FPADD_RNE_EN.
- When defined: S3 rounds to nearest, ties to even, using the guard/round/sticky bits. A mantissa carry from rounding renormalises (exponent+1) and may trigger overflow. Latency is unchanged.
- When undefined: round toward zero (truncation); the GRS bits are only used for cancellation normalisation.

Test Plan:
- a=0x3F800000, b=0x3F800000, sub=0 → sum=0x40000000 after 3 cycles, flags 0.
- a=0x40400000 (3.0), b=0x3F800000, sub=1 → sum=0x40000000. Also a=0x3FC00000, b=0xBFC00000, sub=0 → sum=0x00000000.
- a=0x7F7FFFFF, b=0x7F7FFFFF → sum=0x7F800000, overflow=1. Also a=0x7F800000, b=0xFF800000 → sum=0x7FC00000.
- Shift saturation: a=0x4B800000, b=0x33800000 → sum=0x4B800000 without FPADD_RNE_EN. With FPADD_RNE_EN, a=0x3F800000, b=0x33800000 (exact tie) → 0x3F800000 (tie to even), and b=0x33800001 → 0x3F800001.
- Back-to-back: issue 4 pairs on consecutive cycles with out_ready=1 → 4 results on consecutive cycles in order. Then hold out_ready=0 for 5 cycles → in_ready=0, sum stable, no result lost or duplicated.
- Assert rst with 2 operations in flight → out_valid=0 the next cycle, no stale result emerges, and the first post-reset operation returns correctly after 3 cycles.
